gmii_rx_frame_checker: RTL and testbench
========================================

Name: gmii_rx_frame_checker

Overview:
Consumes the byte-wide GMII receive stream produced by the RGMII-to-GMII conversion stage and turns it into a framed payload stream for the UDP/packet layer. It strips the preamble and SFD and checks the Ethernet FCS (CRC-32). It also removes the 4 FCS bytes from the output stream, and reports per-frame status (CRC ok, error, length) on the last payload byte. All logic runs on the PHY-recovered receive clock.

Parameters:
MIN_FRAME, 64, minimum legal frame length in bytes, post-SFD, FCS included; shorter frames are flagged runt.
MAX_FRAME, 1518, maximum legal frame length in bytes, FCS included; longer frames are flagged oversize.
LEN_W, 11, width of the payload length counter; the counter saturates at 2^LEN_W-1.

Ports:
GMII_RX_CLK_i  in  1  receive clock; sole clock of the block.
reset_n  in  1  synchronous, active-low reset.
GMII_RX_RXD_i  in  8  GMII receive data.
GMII_RX_DV_i  in  1  GMII data valid.
GMII_RX_ER_i  in  1  GMII receive error.
out_data  out  8  payload byte; preamble, SFD and FCS excluded.
out_valid  out  1  out_data is valid this cycle.
out_sof  out  1  first payload byte of the frame; qualified by out_valid.
out_eof  out  1  last payload byte of the frame; qualified by out_valid.
out_crc_ok  out  1  FCS check passed; valid only when out_eof=1.
out_frame_err  out  1  frame is bad; valid only when out_eof=1.
out_len  out  LEN_W  payload byte count (FCS excluded); valid only when out_eof=1.

Behaviour:
- One clock domain; reset is synchronous and active-low. While reset_n=0, all outputs are 0, the state is IDLE, and the CRC register is set to 0xFFFFFFFF.
- State machine: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: if DV=1 and RXD=0x55, go to PREAMBLE. If DV=1 and RXD is any other value, go to DROP. ER with DV=0 is ignored.
  - PREAMBLE: RXD=0x55 stays in PREAMBLE; RXD=0xD5 goes to DATA and reloads CRC to 0xFFFFFFFF; any other byte goes to DROP; DV=0 returns to IDLE with no output.
  - DATA: every DV=1 byte is numbered i=0,1,2,… and is pushed into a 4-byte delay line. When byte i+4 arrives, byte i moves from the delay line into a hold register.
  - DROP: discards input until DV=0, then goes to IDLE. Produces no output.
- Output timing:
  - Byte i is driven with out_valid=1 on the edge that samples byte i+5.
  - The final payload byte (index N-5, where N = total post-SFD bytes) is driven with out_valid=1 and out_eof=1 on the edge that first samples DV=0.
  - out_sof=1 on the first valid output of each frame.
  - out_valid is 0 in all other cycles.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, LSB-first, one byte per clock, no final XOR.
  - Updated over all N bytes, FCS included.
  - out_crc_ok=1 iff the register equals 0xDEBB20E3 after the last byte.
- out_frame_err=1 if any of:
  - CRC is bad;
  - ER=1 was seen while DV=1 in DATA;
  - N<MIN_FRAME;
  - N>MAX_FRAME.
- out_len = N-4, saturating at 2^LEN_W-1.
- N≤4: no output at all; the frame is counted as dropped. N=5: a single output byte with out_sof=out_eof=1.
- A new frame may begin on the cycle immediately after DV falls (IDLE is entered in the eof cycle). The minimum IFG is not checked.
- Reset mid-frame: outputs are zeroed immediately and no eof is issued for the partial frame. If DV is still high after reset release, the machine enters DROP unless the current byte is 0x55. A following non-0x55/0xD5 byte then also leads to DROP.

Optional Feature:
GMII_RX_STATS_EN
- Defined: adds three output ports, all cleared by reset and saturating at all-ones:
  - stat_good_cnt (32 bits): increments on the eof cycle when out_frame_err=0.
  - stat_bad_cnt (32 bits): increments on the eof cycle when out_frame_err=1.
  - stat_drop_cnt (16 bits): increments on every entry to DROP, and on every frame with N≤4 at DV fall.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Good short frame: 7×0x55, 0xD5, ASCII "123456789", then 26 39 F4 CB, then DV=0.
  - 9 out_valid bytes 0x31..0x39; sof on 0x31; eof on 0x39, in the cycle DV is first sampled low.
  - out_crc_ok=1, out_len=9, out_frame_err=1 (runt, N=13<64).
- 64-byte good frame (60 payload bytes + correct FCS): out_len=60, out_crc_ok=1, out_frame_err=0; with stats, stat_good_cnt=1.
- Same 64-byte frame with the last FCS byte XOR 0x01: out_crc_ok=0, out_frame_err=1. Same frame with ER=1 for one DATA cycle and correct FCS: out_crc_ok=1, out_frame_err=1.
- Bad SFD: 0x55,0x55,0xAB,… then DV=0 → no out_valid; stat_drop_cnt=1. A valid frame one cycle later is received correctly.
- Boundaries:
  - N=5 → one byte with sof=eof=1.
  - N=4 → no output, drop count +1.
  - 1519-byte frame → out_len=1515, out_frame_err=1.
- Back-to-back frames with a 1-cycle DV gap: both frames are delivered, with correct sof/eof and status each. Assert reset_n=0 mid-DATA → outputs 0 the next cycle, no eof, next frame clean.

Source files
------------

// File: rtl/gmii_rx_frame_checker.sv
// rtl/gmii_rx_frame_checker.sv - GMII RX preamble/SFD strip, FCS check and removal, per-frame status.
// Optional GMII_RX_STATS_EN adds saturating good/bad/drop frame counters.
module gmii_rx_frame_checker #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int LEN_W     = 11
) (
    input  logic             GMII_RX_CLK_i,
    input  logic             reset_n,
    input  logic [7:0]       GMII_RX_RXD_i,
    input  logic             GMII_RX_DV_i,
    input  logic             GMII_RX_ER_i,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_crc_ok,
    output logic             out_frame_err,
    output logic [LEN_W-1:0] out_len
`ifdef GMII_RX_STATS_EN
    ,
    output logic [31:0]      stat_good_cnt,
    output logic [31:0]      stat_bad_cnt,
    output logic [15:0]      stat_drop_cnt
`endif
);

    localparam int CNT_W = (LEN_W > 14) ? LEN_W + 2 : 16;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t            state, state_nxt;
    logic [31:0]       crc;
    logic [31:0]       dline;
    logic [7:0]        hold;
    logic [CNT_W-1:0]  cnt;
    logic              er_seen;
    logic              crc_ok;
    logic              frame_err;
    logic [CNT_W-1:0]  pay_len;
    logic [LEN_W-1:0]  len_sat;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge GMII_RX_CLK_i) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (GMII_RX_DV_i)
                    state_nxt = (GMII_RX_RXD_i == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!GMII_RX_DV_i)                state_nxt = IDLE;
                else if (GMII_RX_RXD_i == 8'h55)  state_nxt = PREAMBLE;
                else if (GMII_RX_RXD_i == 8'hD5)  state_nxt = DATA;
                else                              state_nxt = DROP;
            end
            DATA:    if (!GMII_RX_DV_i) state_nxt = IDLE;
            DROP:    if (!GMII_RX_DV_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cnt holds N (post-SFD bytes seen so far); status is judged from it at DV fall
    always_comb begin
        crc_ok    = (crc == CRC_RESIDUE);
        frame_err = !crc_ok || er_seen
                    || (cnt < CNT_W'(MIN_FRAME)) || (cnt > CNT_W'(MAX_FRAME));
        pay_len   = cnt - CNT_W'(4);
        len_sat   = (pay_len > CNT_W'(LEN_MAX)) ? LEN_MAX : pay_len[LEN_W-1:0];
    end

    always_ff @(posedge GMII_RX_CLK_i) begin
        if (!reset_n) begin
            crc           <= 32'hFFFFFFFF;
            dline         <= '0;
            hold          <= '0;
            cnt           <= '0;
            er_seen       <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_sof       <= 1'b0;
            out_eof       <= 1'b0;
            out_crc_ok    <= 1'b0;
            out_frame_err <= 1'b0;
            out_len       <= '0;
`ifdef GMII_RX_STATS_EN
            stat_good_cnt <= '0;
            stat_bad_cnt  <= '0;
            stat_drop_cnt <= '0;
`endif
        end else begin
            out_valid     <= 1'b0;
            out_sof       <= 1'b0;
            out_eof       <= 1'b0;
            out_crc_ok    <= 1'b0;
            out_frame_err <= 1'b0;
            out_len       <= '0;
            if (state == PREAMBLE && GMII_RX_DV_i && GMII_RX_RXD_i == 8'hD5) begin
                crc     <= 32'hFFFFFFFF;
                cnt     <= '0;
                er_seen <= 1'b0;
            end
            if (state == DATA) begin
                if (GMII_RX_DV_i) begin
                    dline <= {dline[23:0], GMII_RX_RXD_i};
                    crc   <= crc_byte(crc, GMII_RX_RXD_i);
                    if (GMII_RX_ER_i) er_seen <= 1'b1;
                    if (cnt != '1) cnt <= cnt + CNT_W'(1);
                    if (cnt >= CNT_W'(4)) hold <= dline[31:24];
                    if (cnt >= CNT_W'(5)) begin
                        out_valid <= 1'b1;
                        out_data  <= hold;
                        out_sof   <= (cnt == CNT_W'(5));
                    end
                end else if (cnt >= CNT_W'(5)) begin
                    // hold already carries byte N-5; the 4 delay-line bytes are the FCS
                    out_valid     <= 1'b1;
                    out_data      <= hold;
                    out_sof       <= (cnt == CNT_W'(5));
                    out_eof       <= 1'b1;
                    out_crc_ok    <= crc_ok;
                    out_frame_err <= frame_err;
                    out_len       <= len_sat;
`ifdef GMII_RX_STATS_EN
                    if (frame_err) begin
                        if (stat_bad_cnt != '1) stat_bad_cnt <= stat_bad_cnt + 32'd1;
                    end else begin
                        if (stat_good_cnt != '1) stat_good_cnt <= stat_good_cnt + 32'd1;
                    end
`endif
                end
            end
`ifdef GMII_RX_STATS_EN
            if ((state != DROP && state_nxt == DROP)
                || (state == DATA && !GMII_RX_DV_i && cnt < CNT_W'(5))) begin
                if (stat_drop_cnt != '1) stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// tb/tb_gmii_rx_frame_checker.sv - table-driven scoreboard bench for gmii_rx_frame_checker.
module tb_gmii_rx_frame_checker;

    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       rxd;
    logic             dv;
    logic             er;
    logic [7:0]       out_data;
    logic             out_valid, out_sof, out_eof, out_crc_ok, out_frame_err;
    logic [LEN_W-1:0] out_len;
`ifdef GMII_RX_STATS_EN
    logic [31:0]      stat_good_cnt, stat_bad_cnt;
    logic [15:0]      stat_drop_cnt;
`endif

    always #5 clk = ~clk;

    gmii_rx_frame_checker #(.MIN_FRAME(64), .MAX_FRAME(1518), .LEN_W(LEN_W)) dut (
        .GMII_RX_CLK_i (clk),
        .reset_n       (reset_n),
        .GMII_RX_RXD_i (rxd),
        .GMII_RX_DV_i  (dv),
        .GMII_RX_ER_i  (er),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_sof       (out_sof),
        .out_eof       (out_eof),
        .out_crc_ok    (out_crc_ok),
        .out_frame_err (out_frame_err),
        .out_len       (out_len)
`ifdef GMII_RX_STATS_EN
        ,
        .stat_good_cnt (stat_good_cnt),
        .stat_bad_cnt  (stat_bad_cnt),
        .stat_drop_cnt (stat_drop_cnt)
`endif
    );

    typedef struct {
        logic [7:0] data;
        bit         sof;
        bit         eof;
        bit         crc_ok;
        bit         err;
        int         len;
    } exp_t;

    typedef struct {
        int         plen;
        bit         ascii;
        logic [7:0] seed;
        logic [7:0] fcs_xor;
        int         er_at;
        int         gap;
        bit         crc_ok;
        bit         err;
        int         len;
    } frame_t;

    exp_t   sbq[$];
    exp_t   mon_e;
    frame_t tbl[11];
    int     checks = 0;
    int     errors = 0;
    int     eof_req = 0;
    int     eof_done = 0;
    bit     eof_expect = 1'b0;
    int     exp_good = 0, exp_bad = 0, exp_drop = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if ((r[0] ^ d[k]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
            else                       r = r >> 1;
        end
        return r;
    endfunction

    task automatic drive(input bit v, input logic [7:0] d, input bit e);
        @(negedge clk);
        dv  = v;
        rxd = d;
        er  = e;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_sof"}, out_sof, 0);
        chk({tag, "_eof"}, out_eof, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_crc_ok"}, out_crc_ok, 0);
        chk({tag, "_err"}, out_frame_err, 0);
        chk({tag, "_len"}, out_len, 0);
    endtask

    task automatic check_stats(input string tag);
`ifdef GMII_RX_STATS_EN
        chk({tag, "_good_cnt"}, stat_good_cnt, exp_good);
        chk({tag, "_bad_cnt"}, stat_bad_cnt, exp_bad);
        chk({tag, "_drop_cnt"}, stat_drop_cnt, exp_drop);
`else
        if (tag.len() < 0) chk(tag, 0, 1);
`endif
    endtask

    task automatic send_frame(input frame_t f);
        logic [7:0]  fr[$];
        logic [31:0] c;
        exp_t        e;
        int          n;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < f.plen; i++) begin
            fr.push_back(f.ascii ? 8'h31 + 8'(i) : f.seed + 8'(i));
            c = crc_upd(c, fr[i]);
        end
        c = ~c;
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
        fr.push_back(c[23:16]);
        fr.push_back(c[31:24]);
        n = fr.size();
        fr[n-1] = fr[n-1] ^ f.fcs_xor;
        if (n >= 5) begin
            for (int i = 0; i <= n - 5; i++) begin
                e.data   = fr[i];
                e.sof    = (i == 0);
                e.eof    = (i == n - 5);
                e.crc_ok = f.crc_ok;
                e.err    = f.err;
                e.len    = f.len;
                sbq.push_back(e);
            end
            if (f.err) exp_bad++;
            else       exp_good++;
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < n; i++) drive(1'b1, fr[i], i == f.er_at);
        drive(1'b0, 8'h00, 1'b0);
        eof_expect = (n >= 5);
        eof_req++;
        for (int g = 1; g < f.gap; g++) drive(1'b0, 8'h00, 1'b0);
    endtask

    // eof must appear exactly on the edge that first samples DV low
    always @(posedge clk) begin
        #1;
        if (eof_req != eof_done) begin
            if (eof_expect) chk("eof_timing", out_valid && out_eof, 1);
            else            chk("runt_no_valid", out_valid, 0);
            eof_done = eof_req;
        end
    end

    always @(negedge clk) begin
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", out_valid, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("data", out_data, mon_e.data);
                chk("sof", out_sof, mon_e.sof);
                chk("eof", out_eof, mon_e.eof);
                if (mon_e.eof) begin
                    chk("crc_ok", out_crc_ok, mon_e.crc_ok);
                    chk("frame_err", out_frame_err, mon_e.err);
                    chk("len", out_len, mon_e.len);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        exp_t e;
        //         plen ascii seed   xor    er  gap ok err len
        tbl[0]  = '{9,    1, 8'h00, 8'h00, -1, 3, 1, 1, 9};
        tbl[1]  = '{60,   0, 8'h10, 8'h00, -1, 3, 1, 0, 60};
        tbl[2]  = '{60,   0, 8'h10, 8'h01, -1, 3, 0, 1, 60};
        tbl[3]  = '{60,   0, 8'h10, 8'h00, 10, 3, 1, 1, 60};
        tbl[4]  = '{1,    0, 8'hA0, 8'h00, -1, 3, 1, 1, 1};
        tbl[5]  = '{0,    0, 8'h00, 8'h00, -1, 3, 0, 0, 0};
        tbl[6]  = '{1515, 0, 8'h00, 8'h00, -1, 3, 1, 1, 1515};
        tbl[7]  = '{1514, 0, 8'h40, 8'h00, -1, 1, 1, 0, 1514};
        tbl[8]  = '{46,   0, 8'h77, 8'h00, -1, 1, 1, 1, 46};
        tbl[9]  = '{60,   0, 8'h22, 8'h00, -1, 3, 1, 0, 60};
        tbl[10] = '{59,   0, 8'h05, 8'h00, -1, 3, 1, 1, 59};

        reset_n = 1'b0;
        dv = 1'b0;
        rxd = 8'h00;
        er = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        check_stats("reset");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        for (int t = 0; t < 11; t++) send_frame(tbl[t]);
        drive(1'b0, 8'h00, 1'b0);
        check_stats("table");

        // bad SFD, then a valid frame after a single idle cycle
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hAB, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        exp_drop++;
        drive(1'b0, 8'h00, 1'b0);
        send_frame(tbl[1]);
        drive(1'b0, 8'h00, 1'b0);
        check_stats("bad_sfd");

        // reset while in DATA: bytes already delivered stay, no eof for the rest
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i <= 4; i++) begin
            e.data = 8'h30 + 8'(i);
            e.sof = (i == 0);
            e.eof = 1'b0;
            e.crc_ok = 1'b0;
            e.err = 1'b0;
            e.len = 0;
            sbq.push_back(e);
        end
        for (int i = 0; i < 10; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        rxd = 8'h12;
        @(posedge clk);
        #1;
        check_zero("midreset");
        exp_good = 0;
        exp_bad = 0;
        exp_drop = 0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_drop++;
        drive(1'b1, 8'h34, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        send_frame(tbl[9]);
        drive(1'b0, 8'h00, 1'b0);
        check_stats("after_reset");

        repeat (4) drive(1'b0, 8'h00, 1'b0);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
